pattern_detector: RTL

PATTERN_DETECTOR -- requirements
Module: pattern_detector

---
 rtl/pattern_detector_pkg.sv | 24 ++
 rtl/pattern_detector_sat_counter.sv | 23 ++
 rtl/pattern_detector.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pattern_detector_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encodings
// and the helper that clamps a requested pattern length into the legal range.
package pattern_detector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        ARMED = 2'b10
    } state_t;

    // A zero length is treated as one bit; anything above the maximum is
    // trimmed to the maximum supported pattern length.
    function automatic logic [31:0] clamp_len(input logic [31:0] len,
                                              input logic [31:0] max_len);
        if (len == 32'd0) begin
            return 32'd1;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on clr.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count register with synchronous active-low reset and clear priority.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector with a run-time loadable pattern, length and
// overlap mode. Produces a registered one-cycle match pulse and a
// saturating match count.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int  MAX_LEN = 8,
    parameter int  CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               w,
    input  logic               enable,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic [1:0]         state
);

    state_t             state_reg, state_next;
    logic [MAX_LEN-1:0] pattern_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               overlap_reg;
    logic [MAX_LEN-1:0] history_reg, history_next;
    logic [LEN_W-1:0]   fill_reg, fill_next;
    logic               z_reg;

    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic               sample;
    logic               hit;

    // Only the low len bits of history and pattern take part in the compare.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
        assign len_mask[gi] = (gi < int'(len_reg));
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: load always restarts filling, enabled samples settle
    // in ARMED once the window is full, the unused code falls back to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cfg_load) state_next = FILL;
            end
            FILL, ARMED: begin
                if (cfg_load) begin
                    state_next = FILL;
                end else if (sample) begin
                    state_next = (fill_next == len_reg) ? ARMED : FILL;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift/fill datapath and match detection for the current edge.
    always_comb begin
        sample       = enable && !cfg_load && ((state_reg == FILL) || (state_reg == ARMED));
        hist_shift   = (history_reg << 1) | MAX_LEN'(w);
        fill_inc     = (fill_reg < len_reg) ? (fill_reg + LEN_W'(1)) : fill_reg;
        hit          = sample && (fill_inc == len_reg)
                       && (((hist_shift ^ pattern_reg) & len_mask) == '0);
        history_next = history_reg;
        fill_next    = fill_reg;
        if (sample) begin
            history_next = hist_shift;
            fill_next    = (hit && !overlap_reg) ? '0 : fill_inc;
        end
    end

    // Configuration, history, fill and registered match pulse.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pattern_reg <= '0;
            len_reg     <= LEN_W'(MAX_LEN);
            overlap_reg <= 1'b1;
            history_reg <= '0;
            fill_reg    <= '0;
            z_reg       <= 1'b0;
        end else if (cfg_load) begin
            pattern_reg <= cfg_pattern;
            len_reg     <= LEN_W'(clamp_len(32'(cfg_len), 32'(MAX_LEN)));
            overlap_reg <= cfg_overlap;
            history_reg <= '0;
            fill_reg    <= '0;
            z_reg       <= 1'b0;
        end else begin
            history_reg <= history_next;
            fill_reg    <= fill_next;
            z_reg       <= hit;
        end
    end

    // Output drive from registered state.
    always_comb begin
        state = state_reg;
        z     = z_reg;
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_count (
        .clock  (clock),
        .resetn (resetn),
        .clr    (cfg_load),
        .inc    (hit),
        .count  (match_count)
    );

endmodule
